// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state encoding and error codes for the UART frame decoder
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_BADLEN   = 2'd0;
    localparam logic [1:0] ERR_CHKSUM   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// rtl/uart_frame_decoder_if.sv - payload output stream of the frame decoder
interface uart_frame_decoder_if;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_last, output m_valid, input  m_ready);
    modport slave  (input  m_data, input  m_last, input  m_valid, output m_ready);
endinterface

// File: rtl/uart_frame_fifo.sv
// rtl/uart_frame_fifo.sv - commit/rewind FIFO; readers only see entries up to the commit pointer
module uart_frame_fifo #(
    parameter int Depth = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [8:0]               wr_data,
    input  logic                     commit,
    input  logic                     rewind,
    input  logic                     rd_en,
    output logic                     full,
    output logic [8:0]               rd_data,
    output logic [$clog2(Depth):0]   level
);
    localparam int PW = $clog2(Depth) + 1;

    logic [8:0]    r_mem [Depth];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_commit_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_rd_fire;

    // Full is tentative: uncommitted writes count against space
    assign full      = (r_wr_ptr - r_rd_ptr) == PW'(Depth);
    assign level     = r_commit_ptr - r_rd_ptr;
    assign rd_data   = r_mem[r_rd_ptr[PW-2:0]];
    assign w_rd_fire = rd_en && (r_rd_ptr != r_commit_ptr);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr[PW-2:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
        end else begin
            if (rewind) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (commit) begin
                r_commit_ptr <= r_wr_ptr;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - extracts SYNC/LEN/payload/CHK frames and releases checked payload
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int         FifoDepth     = 64,
    parameter int         MaxLen        = 32,
    parameter logic [7:0] SyncByte      = SYNC_BYTE_DEFAULT,
    parameter int         TimeoutCycles = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_data_ready,
    uart_frame_decoder_if.master         m_if,
    output logic                         frame_ok,
    output logic                         frame_err,
    output logic [1:0]                   err_code,
    output logic [$clog2(FifoDepth):0]   fifo_level
);
    localparam int             TW       = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TimeoutCycles - 1);
    localparam logic [7:0]     MAX_LEN  = 8'(MaxLen);

    state_t        r_state, w_next_state;
    logic          r_rx_prev;
    logic [7:0]    r_len, r_chk, r_cnt;
    logic [TW-1:0] r_tmo;

    logic          w_accept, w_expire, w_last_byte, w_len_ok, w_full;
    logic          w_wr_en, w_commit, w_rewind, w_load_len, w_ok, w_err;
    logic [1:0]    w_err_code;
    logic [8:0]    w_rd_data;

    assign w_accept    = rx_data_ready && !r_rx_prev;
    // A byte arriving in the expiry cycle cancels the timeout
    assign w_expire    = (r_state != ST_HUNT) && !w_accept && (r_tmo == TMO_LAST);
    assign w_last_byte = (r_cnt == r_len - 8'd1);
    assign w_len_ok    = (rx_data != 8'd0) && (rx_data <= MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && rx_data == SyncByte) w_next_state = ST_LEN;
            end
            ST_LEN: begin
                if (w_expire)      w_next_state = ST_HUNT;
                else if (w_accept) w_next_state = w_len_ok ? ST_PAYLOAD : ST_HUNT;
            end
            ST_PAYLOAD: begin
                if (w_expire)                     w_next_state = ST_HUNT;
                else if (w_accept && w_full)      w_next_state = ST_HUNT;
                else if (w_accept && w_last_byte) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_expire || w_accept) w_next_state = ST_HUNT;
            end
            default: w_next_state = ST_HUNT;
        endcase
    end

    always_comb begin
        w_wr_en    = 1'b0;
        w_commit   = 1'b0;
        w_rewind   = 1'b0;
        w_load_len = 1'b0;
        w_ok       = 1'b0;
        w_err      = 1'b0;
        w_err_code = ERR_BADLEN;
        if (w_expire) begin
            w_rewind   = 1'b1;
            w_err      = 1'b1;
            w_err_code = ERR_TIMEOUT;
        end else if (w_accept) begin
            case (r_state)
                ST_LEN: begin
                    if (w_len_ok) begin
                        w_load_len = 1'b1;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = ERR_BADLEN;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_full) begin
                        w_rewind   = 1'b1;
                        w_err      = 1'b1;
                        w_err_code = ERR_OVERFLOW;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (rx_data == r_chk) begin
                        w_commit = 1'b1;
                        w_ok     = 1'b1;
                    end else begin
                        w_rewind   = 1'b1;
                        w_err      = 1'b1;
                        w_err_code = ERR_CHKSUM;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_prev <= 1'b0;
            r_len     <= '0;
            r_chk     <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_BADLEN;
        end else begin
            r_rx_prev <= rx_data_ready;
            if (w_load_len) begin
                r_len <= rx_data;
                r_chk <= rx_data;
                r_cnt <= '0;
            end else if (w_wr_en) begin
                r_chk <= r_chk ^ rx_data;
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == ST_HUNT || w_accept || w_expire) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            frame_ok  <= w_ok;
            frame_err <= w_err;
            if (w_err) begin
                err_code <= w_err_code;
            end
        end
    end

    uart_frame_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_data ({w_last_byte, rx_data}),
        .commit  (w_commit),
        .rewind  (w_rewind),
        .rd_en   (m_if.m_ready),
        .full    (w_full),
        .rd_data (w_rd_data),
        .level   (fifo_level)
    );

    assign m_if.m_valid = (fifo_level != '0);
    assign m_if.m_data  = w_rd_data[7:0];
    assign m_if.m_last  = w_rd_data[8];

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - table-driven and scoreboard bench for uart_frame_decoder
module tb_uart_frame_decoder;
    import uart_frame_pkg::*;

    localparam int DEPTH  = 64;
    localparam int MAXLEN = 32;
    localparam int TMO    = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_ready = 1'b0;
    logic       frame_ok, frame_err;
    logic [1:0] err_code;
    logic [6:0] fifo_level;

    uart_frame_decoder_if m_if ();

    always #5 clk = ~clk;

    uart_frame_decoder #(
        .FifoDepth     (DEPTH),
        .MaxLen        (MAXLEN),
        .SyncByte      (8'hAA),
        .TimeoutCycles (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .m_if          (m_if),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .fifo_level    (fifo_level)
    );

    int         checks = 0;
    int         errors = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    logic [1:0] last_code = 2'd0;
    logic [8:0] exp_q [$];

    typedef struct {
        string      name;
        logic [7:0] len;
        logic [7:0] base;
        logic [7:0] step;
        bit         bad_chk;
        bit         exp_ok;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_ok) ok_cnt++;
            if (frame_err) begin
                err_cnt++;
                last_code = err_code;
            end
            if (m_if.m_valid && m_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", {m_if.m_last, m_if.m_data});
                end else begin
                    check("m_byte", {23'd0, m_if.m_last, m_if.m_data}, {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk);
        #1;
        rx_data       = b;
        rx_data_ready = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] base, input logic [7:0] step,
                              input bit bad_chk, input bit push, input int hold);
        logic [7:0] chk;
        logic [7:0] b;
        chk = len;
        send_byte(8'hAA, hold);
        send_byte(len, hold);
        if (len >= 8'd1 && len <= 8'(MAXLEN)) begin
            for (int i = 0; i < int'(len); i++) begin
                b   = base + step * 8'(i);
                chk = chk ^ b;
                if (push) exp_q.push_back({(i == int'(len) - 1), b});
                send_byte(b, hold);
            end
            send_byte(bad_chk ? (chk ^ 8'h01) : chk, hold);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_m_valid"},    {31'd0, m_if.m_valid}, 32'd0);
        check({tag, "_fifo_level"}, {25'd0, fifo_level},   32'd0);
        check({tag, "_frame_ok"},   {31'd0, frame_ok},     32'd0);
        check({tag, "_frame_err"},  {31'd0, frame_err},    32'd0);
        check({tag, "_err_code"},   {30'd0, err_code},     32'd0);
        check({tag, "_state"},      {30'd0, dut.r_state},  {30'd0, ST_HUNT});
    endtask

    initial begin
        int ok0, err0;
        m_if.m_ready = 1'b1;

        vecs[0] = '{"basic",     8'h03, 8'h11, 8'h11, 1'b0, 1'b1, ERR_BADLEN};
        vecs[1] = '{"bad_chk",   8'h03, 8'h11, 8'h11, 1'b1, 1'b0, ERR_CHKSUM};
        vecs[2] = '{"len_zero",  8'h00, 8'h00, 8'h00, 1'b0, 1'b0, ERR_BADLEN};
        vecs[3] = '{"len_33",    8'h21, 8'h00, 8'h00, 1'b0, 1'b0, ERR_BADLEN};
        vecs[4] = '{"sync_data", 8'h05, 8'hAA, 8'h01, 1'b0, 1'b1, ERR_BADLEN};
        vecs[5] = '{"len_max",   8'h20, 8'h00, 8'h03, 1'b0, 1'b1, ERR_BADLEN};
        vecs[6] = '{"len_one",   8'h01, 8'hAA, 8'h00, 1'b0, 1'b1, ERR_BADLEN};

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        send_byte(8'h37, 1);
        repeat (3) @(posedge clk);
        check("noise_ignored", {24'd0, 8'(ok_cnt + err_cnt)}, 32'd0);

        for (int v = 0; v < 7; v++) begin
            ok0  = ok_cnt;
            err0 = err_cnt;
            send_frame(vecs[v].len, vecs[v].base, vecs[v].step, vecs[v].bad_chk, vecs[v].exp_ok, 1);
            repeat (40) @(posedge clk);
            #1;
            check({vecs[v].name, "_ok"},  32'(ok_cnt - ok0),   {31'd0, vecs[v].exp_ok});
            check({vecs[v].name, "_err"}, 32'(err_cnt - err0), {31'd0, !vecs[v].exp_ok});
            if (!vecs[v].exp_ok) check({vecs[v].name, "_code"}, {30'd0, last_code}, {30'd0, vecs[v].exp_code});
            check({vecs[v].name, "_level"}, {25'd0, fifo_level}, 32'd0);
            check({vecs[v].name, "_drained"}, 32'(exp_q.size()), 32'd0);
        end

        // CHK accepted on one edge must show frame_ok and m_valid right after it
        m_if.m_ready = 1'b0;
        exp_q.push_back({1'b1, 8'h5A});
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        send_byte(8'h5A, 1);
        send_byte(8'h5B, 1);
        check("lat_frame_ok", {31'd0, frame_ok}, 32'd1);
        check("lat_m_valid", {31'd0, m_if.m_valid}, 32'd1);
        @(posedge clk);
        #1;
        check("lat_pulse_width", {31'd0, frame_ok}, 32'd0);
        m_if.m_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Timeout, then a recovery frame
        err0 = err_cnt;
        send_byte(8'hAA, 1);
        send_byte(8'h02, 1);
        send_byte(8'h55, 1);
        repeat (TMO - 20) @(posedge clk);
        check("tmo_not_early", 32'(err_cnt - err0), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("tmo_err", 32'(err_cnt - err0), 32'd1);
        check("tmo_code", {30'd0, last_code}, {30'd0, ERR_TIMEOUT});
        ok0 = ok_cnt;
        exp_q.push_back({1'b1, 8'h7E});
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        send_byte(8'h7E, 1);
        send_byte(8'h7F, 1);
        repeat (5) @(posedge clk);
        check("tmo_recover_ok", 32'(ok_cnt - ok0), 32'd1);

        // Overflow: fill 64 committed entries, third frame must be dropped
        m_if.m_ready = 1'b0;
        send_frame(8'h20, 8'h00, 8'h01, 1'b0, 1'b1, 1);
        send_frame(8'h20, 8'h40, 8'h01, 1'b0, 1'b1, 1);
        err0 = err_cnt;
        send_byte(8'hAA, 1);
        send_byte(8'h20, 1);
        send_byte(8'h99, 1);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_err", 32'(err_cnt - err0), 32'd1);
        check("ovf_code", {30'd0, last_code}, {30'd0, ERR_OVERFLOW});
        check("ovf_level", {25'd0, fifo_level}, 32'd64);
        m_if.m_ready = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_level_empty", {25'd0, fifo_level}, 32'd0);

        // Held strobes count once
        ok0 = ok_cnt;
        send_frame(8'h02, 8'h10, 8'h10, 1'b0, 1'b1, 4);
        repeat (10) @(posedge clk);
        check("hold_ok", 32'(ok_cnt - ok0), 32'd1);
        check("hold_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-payload with committed data pending
        m_if.m_ready = 1'b0;
        send_frame(8'h02, 8'h21, 8'h01, 1'b0, 1'b1, 1);
        send_byte(8'hAA, 4);
        send_byte(8'h05, 4);
        send_byte(8'h01, 4);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        m_if.m_ready = 1'b1;
        ok0 = ok_cnt;
        send_frame(8'h03, 8'h01, 8'h02, 1'b0, 1'b1, 4);
        repeat (10) @(posedge clk);
        check("post_rst_ok", 32'(ok_cnt - ok0), 32'd1);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
